lsb_queue: RTL
==============

LSB_QUEUE -- requirements
Module: lsb_queue

Interface
REQ-001 SHALL have parameter LSB_DEPTH, default 8: entry count, power of two.
REQ-002 SHALL have parameter ROB_W, default 4: ROB id width.
REQ-003 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have port rob_clear  input  1  mispredict flush.
REQ-007 SHALL have port rob_head_id  input  ROB_W  id of ROB head entry.
REQ-008 SHALL have port is_ins  input  1  decoder pushes one memory op.
REQ-009 SHALL have port ins_op  input  3  LB/LH/LW/LBU/LHU/SB/SH/SW code.
REQ-010 SHALL have port ins_rob_id  input  ROB_W  ROB slot of pushed op.
REQ-011 SHALL have ports ins_q1_busy/ins_q2_busy  input  1 each  operand pending.
REQ-012 SHALL have ports ins_q1/ins_q2  input  ROB_W each  producing ROB id.
REQ-013 SHALL have ports ins_v1/ins_v2  input  32 each  operand values (base, store data).
REQ-014 SHALL have port ins_imm  input  32  sign-extended offset.
REQ-015 SHALL have port lsb_full  output  1  no room for push.
REQ-016 SHALL have ports rs_has_output, rs_rob_id, rs_output  input  1/ROB_W/32  ALU broadcast.
REQ-017 SHALL have ports mem_req, mem_we  output  1 each  request, write.
REQ-018 SHALL have ports mem_addr, mem_wdata  output  32 each; mem_size  output  2  byte/half/word.
REQ-019 SHALL have ports mem_done  input  1, mem_rdata  input  32  completion, load data.
REQ-020 SHALL have ports lsb_has_output, lsb_rob_id, lsb_output  output  1/ROB_W/32  result broadcast.

Function
REQ-021 SHALL be a circular FIFO, head/tail ROB-style wrap modulo LSB_DEPTH, plus count.
REQ-022 SHALL drive lsb_full=1 when count >= LSB_DEPTH-1 (one-slot margin for in-flight decode).
REQ-023 SHALL accept push on is_ins regardless of lsb_full; decoder guarantees no overflow.
REQ-024 SHALL wake pending operands when rs_has_output or lsb_has_output matches stored Q, incl. the pushed entry in the same cycle.
REQ-025 SHALL execute only the head entry, in program order; load when both operands ready; store additionally requires ins_rob_id == rob_head_id.
REQ-026 SHALL use FSM IDLE->WAIT_MEM on issue (mem_req=1, addr=v1+imm wrapping 32-bit, wdata=v2, size from op); WAIT_MEM->IDLE on mem_done.
REQ-027 SHALL hold mem_req and all mem_* outputs stable in WAIT_MEM until mem_done.
REQ-028 SHALL on mem_done pop head and pulse lsb_has_output exactly one cycle next edge; load value byte/half sign- or zero-extended from mem_rdata; store value 0.
REQ-029 SHALL on rob_clear invalidate all entries, head=tail=count=0; in-flight transaction SHALL complete (req held to mem_done) with its broadcast suppressed.
REQ-030 SHALL ignore is_ins in a cycle with rob_clear.
REQ-031 SHALL, with rdy_in low, hold every register and keep outputs constant.
REQ-032 SHALL pass unaligned addresses unchanged; alignment is not checked.

Reset
REQ-033 SHALL on rst_in low immediately clear: head, tail, count, all valid bits, FSM=IDLE, mem_req=0, mem_we=0, lsb_has_output=0, mem_addr/mem_wdata/lsb_output/lsb_rob_id=0.
REQ-034 SHALL leave reset synchronously to clk_in; first push accepted first edge after rst_in high.

Structure
REQ-035 SHALL take LSB_DEPTH, ROB_W and memory-op encodings from shared const package used by ROB and decoder.
REQ-036 SHALL place load extension in sub-module lsb_load_ext (op, rdata -> 32-bit value).

Verification
REQ-037 Push LW, v1=0x100, imm=4, ready -> mem_req, addr 0x104, size word; mem_done rdata 0xDEADBEEF -> lsb_output 0xDEADBEEF one cycle.
REQ-038 Push LB, rdata 0x00000080 -> lsb_output 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 Push SW rob_id 3, rob_head_id 2 -> no mem_req; head_id 3 -> mem_we=1, wdata=v2.
REQ-040 Push LW q1_busy Q=5; rs broadcast id 5 value 0x200 same cycle as push -> addr 0x200+imm next cycle.
REQ-041 Push 7 entries depth 8 -> lsb_full=1 at count 7; pop one -> lsb_full=0.
REQ-042 rob_clear mid WAIT_MEM load -> mem_req held to mem_done, no lsb_has_output, count 0 after.

Source files
------------

// File: rtl/lsb_queue_pkg.sv
// rtl/lsb_queue_pkg.sv - shared sizing constants, memory-op encodings and helpers
//
// Purpose: constants shared by the decoder, ROB and load/store buffer, so that
// all three agree on queue depth, ROB id width and the 3-bit memory-op code.
// Ports: none (package).
package lsb_queue_pkg;

  localparam int LSB_DEPTH_DEF = 8;
  localparam int ROB_W_DEF     = 4;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic {
    LSB_IDLE     = 1'b0,
    LSB_WAIT_MEM = 1'b1
  } lsb_state_e;

  function automatic logic op_is_store(input logic [2:0] op);
    logic st;
    case (mem_op_e'(op))
      OP_SB, OP_SH, OP_SW: st = 1'b1;
      default:             st = 1'b0;
    endcase
    return st;
  endfunction

  function automatic logic [1:0] op_size(input logic [2:0] op);
    logic [1:0] sz;
    case (mem_op_e'(op))
      OP_LB, OP_LBU, OP_SB: sz = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
      default:              sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsb_queue_load_ext.sv
// rtl/lsb_queue_load_ext.sv - load result extension for byte/half/word loads
//
// Purpose: turn raw memory read data into the 32-bit architectural load value.
// Ports:
//   op    in  3   memory-op code of the completing access
//   rdata in  32  raw data returned by memory (low bytes hold narrow loads)
//   value out 32  sign- or zero-extended load result
module lsb_load_ext
  import lsb_queue_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rdata,
  output logic [31:0] value
);

  always_comb begin
    value = rdata;
    case (mem_op_e'(op))
      OP_LB:   value = {{24{rdata[7]}}, rdata[7:0]};
      OP_LBU:  value = {24'd0, rdata[7:0]};
      OP_LH:   value = {{16{rdata[15]}}, rdata[15:0]};
      OP_LHU:  value = {16'd0, rdata[15:0]};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/lsb_queue.sv
// rtl/lsb_queue.sv - in-order load/store buffer with operand wakeup and one memory port
//
// Purpose: holds decoded memory ops in program order, captures operand values
// from ALU and LSB result broadcasts, and issues the head entry to memory.
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global enable)
//   rob_clear, rob_head_id              ROB flush and commit point
//   is_ins, ins_*                       decoder push of one memory op
//   lsb_full                            queue has no safe room for another push
//   rs_has_output/rs_rob_id/rs_output   ALU result broadcast
//   mem_req/mem_we/mem_addr/mem_wdata/mem_size, mem_done/mem_rdata  memory port
//   lsb_has_output/lsb_rob_id/lsb_output  this unit's result broadcast
module lsb_queue
  import lsb_queue_pkg::*;
#(
  parameter int LSB_DEPTH = LSB_DEPTH_DEF,
  parameter int ROB_W     = ROB_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             rob_clear,
  input  logic [ROB_W-1:0] rob_head_id,
  input  logic             is_ins,
  input  logic [2:0]       ins_op,
  input  logic [ROB_W-1:0] ins_rob_id,
  input  logic             ins_q1_busy,
  input  logic             ins_q2_busy,
  input  logic [ROB_W-1:0] ins_q1,
  input  logic [ROB_W-1:0] ins_q2,
  input  logic [31:0]      ins_v1,
  input  logic [31:0]      ins_v2,
  input  logic [31:0]      ins_imm,
  output logic             lsb_full,
  input  logic             rs_has_output,
  input  logic [ROB_W-1:0] rs_rob_id,
  input  logic [31:0]      rs_output,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_size,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             lsb_has_output,
  output logic [ROB_W-1:0] lsb_rob_id,
  output logic [31:0]      lsb_output
);

  localparam int IDX_W = $clog2(LSB_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [LSB_DEPTH-1:0] ent_valid;
  logic [LSB_DEPTH-1:0] ent_busy1;
  logic [LSB_DEPTH-1:0] ent_busy2;
  logic [2:0]           ent_op  [LSB_DEPTH];
  logic [ROB_W-1:0]     ent_rob [LSB_DEPTH];
  logic [ROB_W-1:0]     ent_q1  [LSB_DEPTH];
  logic [ROB_W-1:0]     ent_q2  [LSB_DEPTH];
  logic [31:0]          ent_v1  [LSB_DEPTH];
  logic [31:0]          ent_v2  [LSB_DEPTH];
  logic [31:0]          ent_imm [LSB_DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;

  lsb_state_e       state;
  logic             squashed;   // in-flight access belongs to flushed work
  logic [2:0]       cur_op;
  logic [ROB_W-1:0] cur_rob;
  logic [31:0]      ext_value;

  logic head_ready;
  logic head_store;
  logic issue;
  logic pop;
  logic push;
  logic push_busy1;
  logic push_busy2;
  logic [31:0] push_v1;
  logic [31:0] push_v2;

  // One slot of slack: the decoder may already have a push in flight when it sees full.
  assign lsb_full = (count >= CNT_W'(LSB_DEPTH - 1));

  assign head_ready = ent_valid[head] && !ent_busy1[head] && !ent_busy2[head];
  assign head_store = op_is_store(ent_op[head]);
  // Stores only go to memory once they are the oldest uncommitted instruction.
  assign issue = rdy_in && (state == LSB_IDLE) && !rob_clear && head_ready &&
                 (!head_store || (ent_rob[head] == rob_head_id));
  assign pop   = rdy_in && (state == LSB_WAIT_MEM) && mem_done && !squashed && !rob_clear;
  assign push  = rdy_in && is_ins && !rob_clear;

  // Operands of the entry being pushed can be satisfied by a same-cycle broadcast.
  always_comb begin
    push_busy1 = ins_q1_busy;
    push_v1    = ins_v1;
    if (ins_q1_busy && rs_has_output && (rs_rob_id == ins_q1)) begin
      push_busy1 = 1'b0;
      push_v1    = rs_output;
    end else if (ins_q1_busy && lsb_has_output && (lsb_rob_id == ins_q1)) begin
      push_busy1 = 1'b0;
      push_v1    = lsb_output;
    end
    push_busy2 = ins_q2_busy;
    push_v2    = ins_v2;
    if (ins_q2_busy && rs_has_output && (rs_rob_id == ins_q2)) begin
      push_busy2 = 1'b0;
      push_v2    = rs_output;
    end else if (ins_q2_busy && lsb_has_output && (lsb_rob_id == ins_q2)) begin
      push_busy2 = 1'b0;
      push_v2    = lsb_output;
    end
  end

  // Queue storage, pointers and wakeup.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ent_valid <= '0;
      ent_busy1 <= '0;
      ent_busy2 <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < LSB_DEPTH; i++) begin
        ent_op[i]  <= '0;
        ent_rob[i] <= '0;
        ent_q1[i]  <= '0;
        ent_q2[i]  <= '0;
        ent_v1[i]  <= '0;
        ent_v2[i]  <= '0;
        ent_imm[i] <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        ent_valid <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end else begin
        for (int i = 0; i < LSB_DEPTH; i++) begin
          if (ent_valid[i] && ent_busy1[i]) begin
            if (rs_has_output && (rs_rob_id == ent_q1[i])) begin
              ent_busy1[i] <= 1'b0;
              ent_v1[i]    <= rs_output;
            end else if (lsb_has_output && (lsb_rob_id == ent_q1[i])) begin
              ent_busy1[i] <= 1'b0;
              ent_v1[i]    <= lsb_output;
            end
          end
          if (ent_valid[i] && ent_busy2[i]) begin
            if (rs_has_output && (rs_rob_id == ent_q2[i])) begin
              ent_busy2[i] <= 1'b0;
              ent_v2[i]    <= rs_output;
            end else if (lsb_has_output && (lsb_rob_id == ent_q2[i])) begin
              ent_busy2[i] <= 1'b0;
              ent_v2[i]    <= lsb_output;
            end
          end
        end
        if (pop) begin
          ent_valid[head] <= 1'b0;
          head            <= head + 1'b1;
        end
        if (push) begin
          ent_valid[tail] <= 1'b1;
          ent_busy1[tail] <= push_busy1;
          ent_busy2[tail] <= push_busy2;
          ent_op[tail]    <= ins_op;
          ent_rob[tail]   <= ins_rob_id;
          ent_q1[tail]    <= ins_q1;
          ent_q2[tail]    <= ins_q2;
          ent_v1[tail]    <= push_v1;
          ent_v2[tail]    <= push_v2;
          ent_imm[tail]   <= ins_imm;
          tail            <= tail + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  lsb_load_ext u_load_ext (
    .op    (cur_op),
    .rdata (mem_rdata),
    .value (ext_value)
  );

  // Memory-port FSM with registered request and broadcast outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= LSB_IDLE;
      squashed       <= 1'b0;
      cur_op         <= '0;
      cur_rob        <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_size       <= '0;
      lsb_has_output <= 1'b0;
      lsb_rob_id     <= '0;
      lsb_output     <= '0;
    end else if (rdy_in) begin
      lsb_has_output <= 1'b0;
      case (state)
        LSB_IDLE: begin
          if (issue) begin
            state     <= LSB_WAIT_MEM;
            squashed  <= 1'b0;
            cur_op    <= ent_op[head];
            cur_rob   <= ent_rob[head];
            mem_req   <= 1'b1;
            mem_we    <= head_store;
            mem_addr  <= ent_v1[head] + ent_imm[head];
            mem_wdata <= ent_v2[head];
            mem_size  <= op_size(ent_op[head]);
          end
        end
        LSB_WAIT_MEM: begin
          if (mem_done) begin
            state    <= LSB_IDLE;
            squashed <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if (!squashed && !rob_clear) begin
              lsb_has_output <= 1'b1;
              lsb_rob_id     <= cur_rob;
              lsb_output     <= op_is_store(cur_op) ? 32'd0 : ext_value;
            end
          end else if (rob_clear) begin
            // The bus transaction cannot be aborted; finish it silently.
            squashed <= 1'b1;
          end
        end
        default: state <= LSB_IDLE;
      endcase
    end
  end

endmodule
